// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed hex seven-segment scanner with leading-zero blanking
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int LZ_BLANK   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);
  localparam int PW = $clog2(PRESCALE);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    wrap, blank;
  always_comb begin
    shadow_d    = load ? value : shadow_q;
    shadow_dp_d = load ? dp_in : shadow_dp_q;
    wrap        = presc_q == PW'(PRESCALE - 1);
    presc_d     = (!enable || wrap) ? '0 : presc_q + PW'(1);
    idx_d       = !enable ? '0 : !wrap ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    // a digit is blank when it and every more-significant nibble are zero
    blank       = LZ_BLANK != 0 && idx_q != '0 && (shadow_q >> {idx_q, 2'b00}) == '0;
    seg_d       = (!enable || blank) ? '1 : GLYPH[shadow_q[{idx_q, 2'b00} +: 4]];
    dp_d        = !enable || !shadow_dp_q[idx_q];
    an_d        = enable ? ~(NUM_DIGITS'(1) << idx_q) : '1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      seg_q       <= '1;
      dp_q        <= 1'b1;
      an_q        <= '1;
    end else begin
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end
  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;
endmodule
